// File: rtl/l1_arb_pkg.sv
// Shared defaults and types for the L1 cacheline-request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l1_arb_pkg;

  localparam int NSTREAMS  = 8;
  localparam int MAX_OUT   = 16;
  localparam int SID_WIDTH = $clog2(NSTREAMS);

  typedef logic [SID_WIDTH-1:0] sid_t;

endpackage

// File: rtl/l1_clreq_arb_if.sv
// Stream-side request/response bundle plus the L2 request/response channel.
// Latency: n/a (wires only).
// Backpressure: i_req_r toward streams, o_req_r from L2; responses are never stalled.
interface l1_clreq_arb_if
  import l1_arb_pkg::*;
#(
  parameter int nstreams  = NSTREAMS,
  parameter int sid_width = $clog2(nstreams)
);

  logic [nstreams-1:0]  i_req_v;
  logic [nstreams-1:0]  i_req_r;
  logic                 o_req_v;
  logic                 o_req_r;
  logic [sid_width-1:0] o_req_sid;
  logic                 i_rsp_v;
  logic [sid_width-1:0] i_rsp_sid;
  logic [nstreams-1:0]  o_rsp_v;

  // Arbiter side.
  modport slave (
    input  i_req_v,
    output i_req_r,
    output o_req_v,
    input  o_req_r,
    output o_req_sid,
    input  i_rsp_v,
    input  i_rsp_sid,
    output o_rsp_v
  );

  // Streams plus L2 side.
  modport master (
    output i_req_v,
    input  i_req_r,
    input  o_req_v,
    output o_req_r,
    input  o_req_sid,
    output i_rsp_v,
    output i_rsp_sid,
    input  o_rsp_v
  );

endinterface

// File: rtl/l1_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
// Latency: 0 cycles (pure logic; the pointer register lives in the parent).
// Backpressure: en_i low forces an all-zero grant; win_o is still reported.
module l1_rr_arb #(
  parameter int nstreams  = 8,
  parameter int sid_width = $clog2(nstreams)
) (
  input  logic [nstreams-1:0]  req_i,
  input  logic [sid_width-1:0] ptr_i,
  input  logic                 en_i,
  output logic [nstreams-1:0]  gnt_o,
  output logic [sid_width-1:0] win_o
);

  logic                 found;
  logic [sid_width-1:0] idx_s;
  int                   idx;

  // Scan ptr, ptr+1, ... with a single wrap; the first set request wins.
  always_comb begin
    found = 1'b0;
    win_o = '0;
    idx   = 0;
    idx_s = '0;
    for (int k = 0; k < nstreams; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= nstreams) idx = idx - nstreams;
      idx_s = sid_width'(idx);
      if (!found && req_i[idx_s]) begin
        found = 1'b1;
        win_o = idx_s;
      end
    end
  end

  // Only the winner is granted, and only when the parent can take a request.
  always_comb begin
    gnt_o = '0;
    if (en_i && found) gnt_o[win_o] = 1'b1;
  end

endmodule

// File: rtl/l1_clreq_arb.sv
// Shares one L2 cacheline-request channel among L1 streams, routes responses back by sid.
// Latency: 1 cycle grant->o_req_v, 1 cycle i_rsp_v->o_rsp_v.
// Backpressure: grants stop while the output stage is stalled or all max_out credits are used.
module l1_clreq_arb
  import l1_arb_pkg::*;
#(
  parameter int nstreams  = NSTREAMS,
  parameter int max_out   = MAX_OUT,
  parameter int sid_width = $clog2(nstreams),
  parameter int cnt_width = $clog2(max_out + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  l1_clreq_arb_if.slave        bus,
  output logic [cnt_width-1:0] o_out_cnt,
  output logic                 o_idle
);

  localparam logic [sid_width-1:0] LAST_SID = sid_width'(nstreams - 1);
  localparam logic [sid_width-1:0] SID_ONE  = sid_width'(1);
  localparam logic [cnt_width-1:0] MAX_CNT  = cnt_width'(max_out);
  localparam logic [cnt_width-1:0] CNT_ONE  = cnt_width'(1);

  logic                 req_v_q,   req_v_d;
  logic [sid_width-1:0] req_sid_q, req_sid_d;
  logic [sid_width-1:0] rr_ptr_q,  rr_ptr_d;
  logic [cnt_width-1:0] cnt_q,     cnt_d;
  logic [nstreams-1:0]  rsp_v_q,   rsp_v_d;

  logic [nstreams-1:0]  gnt;
  logic [sid_width-1:0] win;
  logic                 stage_ld;
  logic                 credit_ok;
  logic                 g_en;
  logic                 grant;

  // The stage accepts a new request when empty or draining this cycle. Gating
  // with reset keeps i_req_r at zero while the block is held in reset.
  assign stage_ld  = ~req_v_q | bus.o_req_r;
  assign credit_ok = (cnt_q < MAX_CNT);
  assign g_en      = reset & stage_ld & credit_ok;

  l1_rr_arb #(
    .nstreams  (nstreams),
    .sid_width (sid_width)
  ) u_rr_arb (
    .req_i (bus.i_req_v),
    .ptr_i (rr_ptr_q),
    .en_i  (g_en),
    .gnt_o (gnt),
    .win_o (win)
  );

  assign grant       = |gnt;
  assign bus.i_req_r = gnt;

  // Output stage load/drain and round-robin pointer advance past the winner.
  always_comb begin
    req_v_d   = req_v_q;
    req_sid_d = req_sid_q;
    rr_ptr_d  = rr_ptr_q;
    if (grant) begin
      req_v_d   = 1'b1;
      req_sid_d = win;
      rr_ptr_d  = (win == LAST_SID) ? '0 : win + SID_ONE;
    end else if (bus.o_req_r) begin
      req_v_d   = 1'b0;
    end
  end

  // Outstanding count: +1 per grant, -1 per response, floor at zero so a
  // stray response cannot wrap the counter and lock out all streams.
  always_comb begin
    cnt_d = cnt_q;
    if (grant && !bus.i_rsp_v) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!grant && bus.i_rsp_v && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // One-hot decode of the returning response to its owning stream.
  always_comb begin
    rsp_v_d = '0;
    if (bus.i_rsp_v) rsp_v_d[bus.i_rsp_sid] = 1'b1;
  end

  // State registers; reset drops any in-flight bookkeeping immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_v_q   <= 1'b0;
      req_sid_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_v_q   <= '0;
    end else begin
      req_v_q   <= req_v_d;
      req_sid_q <= req_sid_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      rsp_v_q   <= rsp_v_d;
    end
  end

  assign bus.o_req_v   = req_v_q;
  assign bus.o_req_sid = req_sid_q;
  assign bus.o_rsp_v   = rsp_v_q;
  assign o_out_cnt     = cnt_q;
  assign o_idle        = (cnt_q == '0) & ~req_v_q;

endmodule

// File: tb/tb_l1_clreq_arb.sv
// Self-checking bench for l1_clreq_arb: directed scenarios plus a randomized soak.
// Latency: n/a.
// Backpressure: bench drives o_req_r and paces L2 responses.
module tb_l1_clreq_arb;
  import l1_arb_pkg::*;

  localparam int NS = NSTREAMS;
  localparam int MO = 4;
  localparam int SW = $clog2(NS);
  localparam int CW = $clog2(MO + 1);

  logic          clk;
  logic          reset;
  logic [CW-1:0] out_cnt;
  logic          idle;

  l1_clreq_arb_if #(.nstreams(NS)) bus ();

  l1_clreq_arb #(
    .nstreams (NS),
    .max_out  (MO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .o_out_cnt (out_cnt),
    .o_idle    (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard queues: expected accepted sids and expected response strobes.
  int            exp_sid_q[$];
  logic [NS-1:0] exp_rsp_q[$];
  bit            sid_chk = 1'b1;
  int            rsp_seen[NS];

  // Random-phase bookkeeping.
  logic [NS-1:0] rq;
  int            waitc[NS];
  int            gnt_cnt[NS];
  int            rsp_base[NS];
  int            model_cnt;
  sid_t          pend[$];

  int seq1 [9] = '{0, 3, 5, 0, 3, 5, 0, 3, 5};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    bus.i_req_v   = '0;
    bus.o_req_r   = 1'b0;
    bus.i_rsp_v   = 1'b0;
    bus.i_rsp_sid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clr_inputs();
    exp_sid_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT hands off a request or a response.
  always @(negedge clk) begin
    if (reset) begin
      if (sid_chk && bus.o_req_v && bus.o_req_r) begin
        if (exp_sid_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mon_sid: unexpected sid %0d, none pending", bus.o_req_sid);
        end else begin
          chk("mon_sid", int'(bus.o_req_sid), exp_sid_q.pop_front());
        end
      end
      if (bus.o_rsp_v != '0) begin
        for (int s = 0; s < NS; s++) if (bus.o_rsp_v[s]) rsp_seen[s]++;
        if (exp_rsp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mon_rsp: unexpected o_rsp_v 0x%0h, none pending", bus.o_rsp_v);
        end else begin
          chk("mon_rsp", int'(bus.o_rsp_v), int'(exp_rsp_q.pop_front()));
        end
      end
    end
  end

  // One randomized cycle: drive at posedge+1, observe and update model at negedge.
  task automatic rnd_cycle(input bit gen, output bit sent);
    int            idx;
    logic [NS-1:0] g;
    if (gen) begin
      for (int s = 0; s < NS; s++)
        if (!rq[s] && ($urandom_range(0, 3) == 0)) rq[s] = 1'b1;
    end
    bus.i_req_v = rq;
    bus.o_req_r = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.i_rsp_v = 1'b0;
    sent = 1'b0;
    if ((pend.size() > 0) && (!gen || ($urandom_range(0, 2) == 0))) begin
      idx = $urandom_range(0, pend.size() - 1);
      bus.i_rsp_v   = 1'b1;
      bus.i_rsp_sid = pend[idx];
      exp_rsp_q.push_back(NS'(1) << pend[idx]);
      pend.delete(idx);
      sent = 1'b1;
    end
    @(negedge clk);
    chk("rnd_cnt", int'(out_cnt), model_cnt);
    chk("rnd_cnt_max", int'(int'(out_cnt) <= MO), 1);
    g = bus.i_req_r;
    chk("rnd_gnt_legal", int'(((g & ~bus.i_req_v) == '0) && $onehot0(g)), 1);
    for (int s = 0; s < NS; s++) begin
      if (g[s]) begin
        chk("rnd_starve", int'(waitc[s] < NS), 1);
        waitc[s] = 0;
        rq[s] = 1'b0;
        gnt_cnt[s]++;
        model_cnt++;
      end else if (rq[s] && (g != '0)) begin
        waitc[s]++;
      end
    end
    if (sent) model_cnt--;
    if (bus.o_req_v && bus.o_req_r) pend.push_back(bus.o_req_sid);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sent;
    bit drained;
    reset = 1'b0;
    clr_inputs();
    @(posedge clk);
    mid();
    // Reset state.
    chk("rst_o_req_v",   int'(bus.o_req_v),   0);
    chk("rst_o_req_sid", int'(bus.o_req_sid), 0);
    chk("rst_o_rsp_v",   int'(bus.o_rsp_v),   0);
    chk("rst_out_cnt",   int'(out_cnt),       0);
    chk("rst_idle",      int'(idle),          1);
    chk("rst_i_req_r",   int'(bus.i_req_r),   0);
    cyc();
    reset = 1'b1;

    // Streams 0,3,5 continuous, L2 always ready and answering each accepted request.
    bus.o_req_r = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      bus.i_req_v = (k < 9) ? 8'b0010_1001 : 8'b0000_0000;
      if (k > 0) begin
        bus.i_rsp_v   = 1'b1;
        bus.i_rsp_sid = SW'(seq1[k-1]);
        exp_rsp_q.push_back(NS'(1) << seq1[k-1]);
      end
      if (k < 9) exp_sid_q.push_back(seq1[k]);
      mid();
      chk("t1_gnt", int'(bus.i_req_r), (k < 9) ? (1 << seq1[k]) : 0);
      cyc();
    end
    bus.i_rsp_v = 1'b0;
    mid();
    chk("t1_cnt_end",  int'(out_cnt), 0);
    chk("t1_idle_end", int'(idle),    1);
    cyc();

    // Credit limit: all streams request, L2 silent until one response.
    do_reset();
    bus.o_req_r = 1'b1;
    bus.i_req_v = '1;
    for (int k = 0; k < 4; k++) begin
      exp_sid_q.push_back(k);
      mid();
      chk("t2_gnt", int'(bus.i_req_r), 1 << k);
      cyc();
    end
    mid();
    chk("t2_cnt_full", int'(out_cnt),     MO);
    chk("t2_no_gnt",   int'(bus.i_req_r), 0);
    cyc();
    mid();
    chk("t2_stage_empty",    int'(bus.o_req_v), 0);
    chk("t2_no_gnt_empty",   int'(bus.i_req_r), 0);
    cyc();
    bus.i_rsp_v   = 1'b1;
    bus.i_rsp_sid = 3'd2;
    exp_rsp_q.push_back(8'b0000_0100);
    mid();
    chk("t2_no_gnt_same_cyc", int'(bus.i_req_r), 0);
    cyc();
    bus.i_rsp_v = 1'b0;
    exp_sid_q.push_back(4);
    mid();
    chk("t2_rsp_strobe", int'(bus.o_rsp_v),   8'b0000_0100);
    chk("t2_cnt_after",  int'(out_cnt),       3);
    chk("t2_gnt_sid4",   int'(bus.i_req_r),   8'b0001_0000);
    cyc();
    mid();
    chk("t2_no_gnt_again", int'(bus.i_req_r), 0);
    chk("t2_cnt_full2",    int'(out_cnt),     MO);
    cyc();

    // Back-pressure with sid 6 held in the stage.
    do_reset();
    bus.o_req_r = 1'b0;
    bus.i_req_v = 8'b0100_0000;
    exp_sid_q.push_back(6);
    mid();
    chk("t3_gnt6", int'(bus.i_req_r), 8'b0100_0000);
    cyc();
    bus.i_req_v = 8'b0000_0010;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("t3_hold_v",   int'(bus.o_req_v),   1);
      chk("t3_hold_sid", int'(bus.o_req_sid), 6);
      chk("t3_hold_gnt", int'(bus.i_req_r),   0);
      cyc();
    end
    bus.o_req_r = 1'b1;
    exp_sid_q.push_back(1);
    mid();
    chk("t3_gnt_on_ready", int'(bus.i_req_r), 8'b0000_0010);
    cyc();
    bus.i_req_v = '0;
    mid();
    cyc();

    // Grant and response in the same cycle at count 3.
    bus.i_req_v = 8'b0000_0100;
    exp_sid_q.push_back(2);
    mid();
    chk("t4_gnt2", int'(bus.i_req_r), 8'b0000_0100);
    chk("t4_cnt2", int'(out_cnt),     2);
    cyc();
    bus.i_req_v   = 8'b0000_1000;
    bus.i_rsp_v   = 1'b1;
    bus.i_rsp_sid = 3'd6;
    exp_rsp_q.push_back(8'b0100_0000);
    exp_sid_q.push_back(3);
    mid();
    chk("t4_cnt3", int'(out_cnt),     3);
    chk("t4_gnt3", int'(bus.i_req_r), 8'b0000_1000);
    cyc();
    bus.i_req_v   = '0;
    bus.i_rsp_sid = 3'd1;
    exp_rsp_q.push_back(8'b0000_0010);
    mid();
    chk("t4_cnt_same", int'(out_cnt),   3);
    chk("t4_rsp6",     int'(bus.o_rsp_v), 8'b0100_0000);
    cyc();
    bus.i_rsp_sid = 3'd2;
    exp_rsp_q.push_back(8'b0000_0100);
    mid();
    cyc();
    bus.i_rsp_sid = 3'd3;
    exp_rsp_q.push_back(8'b0000_1000);
    mid();
    cyc();
    bus.i_rsp_v = 1'b0;
    mid();
    chk("t4_cnt_end",  int'(out_cnt), 0);
    chk("t4_idle_end", int'(idle),    1);
    cyc();

    // Stray response at count 0: counter must not wrap.
    bus.i_rsp_v   = 1'b1;
    bus.i_rsp_sid = 3'd0;
    exp_rsp_q.push_back(8'b0000_0001);
    mid();
    cyc();
    bus.i_rsp_v = 1'b0;
    mid();
    chk("t6_no_wrap", int'(out_cnt),     0);
    chk("t6_rsp0",    int'(bus.o_rsp_v), 8'b0000_0001);
    cyc();

    // Asynchronous reset in the middle of a burst.
    bus.i_req_v = '1;
    bus.o_req_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_sid_q.push_back(4 + k);
      mid();
      chk("t5_gnt", int'(bus.i_req_r), 1 << (4 + k));
      cyc();
    end
    chk("t5_cnt_pre", int'(out_cnt), MO);
    bus.i_req_v = 8'b0010_1000;
    #2;
    reset = 1'b0;
    exp_sid_q.delete();
    exp_rsp_q.delete();
    #1;
    chk("t5_o_req_v",   int'(bus.o_req_v),   0);
    chk("t5_o_req_sid", int'(bus.o_req_sid), 0);
    chk("t5_o_rsp_v",   int'(bus.o_rsp_v),   0);
    chk("t5_cnt",       int'(out_cnt),       0);
    chk("t5_idle",      int'(idle),          1);
    chk("t5_i_req_r",   int'(bus.i_req_r),   0);
    cyc();
    reset = 1'b1;
    exp_sid_q.push_back(3);
    mid();
    chk("t5_first_gnt", int'(bus.i_req_r), 8'b0000_1000);
    cyc();
    bus.i_req_v = 8'b0010_0000;
    exp_sid_q.push_back(5);
    mid();
    chk("t5_second_gnt", int'(bus.i_req_r), 8'b0010_0000);
    cyc();
    bus.i_req_v   = '0;
    bus.i_rsp_v   = 1'b1;
    bus.i_rsp_sid = 3'd3;
    exp_rsp_q.push_back(8'b0000_1000);
    mid();
    cyc();
    bus.i_rsp_sid = 3'd5;
    exp_rsp_q.push_back(8'b0010_0000);
    mid();
    cyc();
    bus.i_rsp_v = 1'b0;
    mid();
    chk("t5_cnt_end",  int'(out_cnt), 0);
    chk("t5_idle_end", int'(idle),    1);
    chk("t5_sid_q_empty", exp_sid_q.size(), 0);
    cyc();

    // Randomized soak with invariant and per-stream accounting checks.
    sid_chk   = 1'b0;
    rq        = '0;
    model_cnt = 0;
    for (int s = 0; s < NS; s++) begin
      waitc[s]    = 0;
      gnt_cnt[s]  = 0;
      rsp_base[s] = rsp_seen[s];
    end
    for (int i = 0; i < 3000; i++) rnd_cycle(1'b1, sent);
    drained = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rnd_cycle(1'b0, sent);
      if (!sent && (pend.size() == 0) && !bus.o_req_v && (rq == '0)) begin
        drained = 1'b1;
        break;
      end
    end
    chk("rnd_drained", int'(drained), 1);
    mid();
    for (int s = 0; s < NS; s++)
      chk("rnd_rsp_eq_gnt", rsp_seen[s] - rsp_base[s], gnt_cnt[s]);
    chk("rnd_cnt_end",     int'(out_cnt),     0);
    chk("rnd_idle_end",    int'(idle),        1);
    chk("rnd_rsp_q_empty", exp_rsp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
